// File: rtl/dm_banked_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dm_banked_ctrl                                               |
// | Brief   : Byte-lane data memory with wait-stated load/store handshake. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module dm_banked_ctrl #(
    parameter int ADDR_BITS   = 11,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        writeEnabled,
    input  logic [1:0]  size,
    input  logic        unsignedLoad,
    input  logic [31:0] address,
    input  logic [31:0] writeInput,
    output logic        ready,
    output logic [31:0] readResult,
    output logic        misaligned
);

    localparam int         c_DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS+1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [1:0]             r_size;
    logic                   r_we;
    logic                   r_uns;
    logic                   r_mis;
    logic [31:0]            r_mem [c_DEPTH];

    logic                   w_mis_in;
    logic                   w_access;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [31:0]            w_word;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [31:0]            w_load;
    logic [3:0]             w_be;
    logic [31:0]            w_wdata;
    logic                   w_unused;

    // Address bits above the word index alias onto the same storage.
    assign w_unused = ^address[31:ADDR_BITS+2];

    assign w_mis_in = ((size == 2'b01) && address[0])
                   || ((size == 2'b10) && (address[1:0] != 2'b00))
                   || (size == 2'b11);

    // The access edge is the one on which the counter is seen at zero.
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0) && !r_mis;
    assign w_idx    = r_addr[ADDR_BITS+1:2];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_word = r_mem[w_idx];
        w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load = w_word;
        w_be   = 4'b1111;
        w_wdata = r_wdata;
        case (r_size)
            2'b00: begin
                w_load  = {{24{w_byte[7] & ~r_uns}}, w_byte};
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_load  = {{16{w_half[15] & ~r_uns}}, w_half};
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_mis      <= 1'b0;
            readResult <= '0;
        end else begin
            if (r_state == S_IDLE && req) begin
                r_addr  <= address[ADDR_BITS+1:0];
                r_wdata <= writeInput;
                r_size  <= size;
                r_we    <= writeEnabled;
                r_uns   <= unsignedLoad;
                r_mis   <= w_mis_in;
                r_cnt   <= w_mis_in ? 4'd0 : c_WAIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !r_we) readResult <= w_load;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_access && r_we) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
    end

    assign ready      = (r_state == S_RESP);
    assign misaligned = ready && r_mis;

endmodule
`default_nettype wire

// File: tb/tb_dm_banked_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_dm_banked_ctrl                                            |
// | Brief   : Scoreboard bench with byte-array reference model.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_dm_banked_ctrl;

    localparam int AB    = 11;
    localparam int W     = 2;
    localparam int NBYTE = 4 * (2 ** AB);

    logic        clock = 1'b0;
    logic        reset, req, writeEnabled, unsignedLoad;
    logic [1:0]  size;
    logic [31:0] address, writeInput;
    logic        ready, misaligned;
    logic [31:0] readResult;

    dm_banked_ctrl #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset), .req(req), .writeEnabled(writeEnabled),
        .size(size), .unsignedLoad(unsignedLoad), .address(address),
        .writeInput(writeInput), .ready(ready), .readResult(readResult),
        .misaligned(misaligned)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          at;
    } exp_t;
    exp_t sbq[$];

    byte unsigned mb [NBYTE];
    logic [31:0]  last_rd;
    int vectors = 0, miscompares = 0;

    function automatic void model_reset();
        for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
        last_rd = 32'h0;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (ready) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ready: cyc=%0d rd=%h mis=%b, required no response",
                         cyc, readResult, misaligned);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (readResult !== e.rd || misaligned !== e.mis || cyc != e.at) begin
                    miscompares++;
                    $display("FAIL response: got rd=%h mis=%b cyc=%0d, required rd=%h mis=%b cyc=%0d",
                             readResult, misaligned, cyc, e.rd, e.mis, e.at);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input bit keep);
        logic        mis;
        int unsigned base, n;
        logic [31:0] val;
        exp_t        e;
        @(negedge clock);
        mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        base = a % NBYTE;
        n    = 1 << sz;
        if (!mis && keep) begin
            if (we) begin
                for (int k = 0; k < int'(n); k++) mb[base + k] = d[8*k +: 8];
            end else begin
                val = 32'h0;
                for (int k = 0; k < int'(n); k++) val = val | (32'(mb[base + k]) << (8 * k));
                if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
                last_rd = val;
            end
        end
        if (keep) begin
            e.mis = mis;
            e.rd  = last_rd;
            e.at  = cyc + 2 + (mis ? 0 : W);
            sbq.push_back(e);
        end
        req = 1'b1; writeEnabled = we; size = sz; unsignedLoad = uns;
        address = a; writeInput = d;
        @(posedge clock);
        #1;
        req = 1'b0;
        // Scramble request inputs while busy; the DUT must use captured values.
        writeEnabled = 1'($urandom); size = 2'($urandom); unsignedLoad = 1'($urandom);
        address = $urandom; writeInput = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < W + 20 && sbq.size() > 0; i++) @(negedge clock);
        if (sbq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = 1'b1;
        size  = 2'b10; writeEnabled = 1'b1; address = 32'h0; writeInput = 32'hFFFF_FFFF;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        req   = 1'b0;
        vectors++;
        if (ready !== 1'b0 || misaligned !== 1'b0 || readResult !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b mis=%b rd=%h, required 0 0 00000000",
                     ready, misaligned, readResult);
        end
        model_reset();
        sbq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req = 1'b0; writeEnabled = 1'b0; size = 2'b00;
        unsignedLoad = 1'b0; address = 32'h0; writeInput = 32'h0;
        model_reset();
        do_reset();

        issue(1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0, 1'b1); drain();
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1122_3344, 1'b1); drain();
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h5555_55AA, 1'b1); drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1); drain();
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0041, 32'h0, 1'b1); drain();
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0, 1'b1); drain();
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0, 1'b1); drain();
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0043, 32'h9999_9999, 1'b1); drain();
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'h9999_9999, 1'b1); drain();
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0044, 32'h0, 1'b1); drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1); drain();
        issue(1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1); drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 1'b1); drain();

        // Last word must also be cleared by reset.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_1FFC, 32'hCAFE_F00D, 1'b1); drain();
        do_reset();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0, 1'b1); drain();

        // Store aborted by reset while waiting: no response, no write.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'h1234_5678, 1'b0);
        do_reset();
        repeat (W + 4) @(negedge clock);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 1'b1); drain();

        for (int t = 0; t < 250; t++) begin
            logic [31:0] a;
            int unsigned idx;
            a   = $urandom;
            idx = $urandom_range(0, 8);
            a[AB+1:2] = (idx == 8) ? {AB{1'b1}} : AB'(idx);
            if ($urandom_range(0, 49) == 0) do_reset();
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'b1);
            drain();
        end

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
